fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Downstream of rect_generator: merges two pixel-write streams (port 0 = rect_generator,
//  port 1 = second draw engine) onto the single frame-buffer memory write port.
//  Round-robin grant with a burst limit. One registered output slot; full
//  throughput (1 beat/clk) under sustained load.
// PARAMETERS
//  DATA_WIDTH  32  pixel word width (arb_data)
//  ADDR_WIDTH  17  frame-buffer word address width (arb_addr)
//  WBEN_WIDTH  4   byte write-enable width (arb_wben)
//  MAX_BURST   8   max consecutive beats granted to one port while the other waits (>=1)
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst          in   1           asynchronous, active-high reset
//  in0_data     in   DATA_WIDTH  port 0 pixel data
//  in0_addr     in   ADDR_WIDTH  port 0 word address
//  in0_wben     in   WBEN_WIDTH  port 0 byte enables
//  in0_rts      in   1           port 0 ready-to-send
//  in0_rtr      out  1           port 0 ready-to-receive
//  in1_data/in1_addr/in1_wben/in1_rts in, in1_rtr out: same as port 0, for port 1
//  mem_data     out  DATA_WIDTH  registered write data to frame buffer
//  mem_addr     out  ADDR_WIDTH  registered write address
//  mem_wben     out  WBEN_WIDTH  registered byte enables
//  mem_valid    out  1           output slot holds a beat
//  mem_ready    in   1           memory accepts the beat this cycle
//  cur_grant    out  1           port currently granted (valid in GRANT state only)
// BEHAVIOUR
//  - Reset: state=IDLE, last_served=1 (port 0 wins the first tie), burst_cnt=0, in0_rtr=in1_rtr=0,
//    mem_valid=0, mem_data/addr/wben=0. Reset mid-operation discards the held beat at once.
//  - Transfer on input k: ink_rts & ink_rtr at the rising edge. Sources hold data stable while rts.
//  - Output slot: free = !mem_valid | mem_ready. Memory consumes on mem_valid & mem_ready.
//    On transfer: mem_* <= ink_*, mem_valid <= 1. Consumed and no transfer -> mem_valid <= 0.
//    While mem_valid & !mem_ready, mem_* hold stable. No beat is lost or duplicated.
//  - Latency: beat accepted at edge N drives mem_valid in cycle N+1.
//  - rtr: in GRANTk, ink_rtr = free and in(other)_rtr = 0. In IDLE both rtr = 0.
//    rtr is combinational from state and mem_ready. It never depends on in*_rts.
//  - FSM, evaluated at each edge:
//    IDLE:   no rts -> IDLE. One rts -> GRANT of that port. Both -> GRANT(!last_served).
//            Cost: one arbitration cycle before the first beat after idle.
//    GRANTk: !ink_rts -> GRANT(other) if other rts, else IDLE. burst_cnt <= 0.
//            Transfer with burst_cnt==MAX_BURST-1 and other rts -> GRANT(other).
//            burst_cnt <= 0 and last_served <= k.
//            Transfer otherwise -> stay. burst_cnt increments, saturating at MAX_BURST-1.
//            A lone requester streams without bubbles.
//            No transfer but rts held (backpressure) -> stay. burst_cnt unchanged.
//  - last_served <= k on every exit from GRANTk.
//  - Switching between ports costs no bubble cycle when the switch is caused by the burst limit.
//  - wben==0 beats are forwarded unchanged. Addresses pass through unchecked.
//  - burst_cnt width = clog2(MAX_BURST), min 1 bit.
// TESTING
//  1 Port0 only, 4 beats addr 0x00101..0x00104, data 0xA0..0xA3, mem_ready=1
//    -> first beat on mem_* 2 clks after rts. Then 4 consecutive mem_valid beats in order.
//  2 Both rts from reset, 12 beats each, MAX_BURST=8 -> 8 port0 beats, then 8 port1 beats,
//    then 4 port0 beats, then 4 port1 beats. No gap at the switches.
//  3 mem_ready low 3 clks while mem_valid=1 -> mem_* stable, granted rtr=0.
//    After release the same beat is consumed exactly once and the stream resumes.
//  4 Port0 20 beats, port1 silent -> 20 back-to-back beats, cur_grant stays 0, no bubble.
//  5 rst pulsed high mid-burst -> mem_valid=0 and rtr=0 immediately.
//    Next tie goes to port 0.
//  6 MAX_BURST=1, both streaming 0x00000.. / 0x10000.. -> mem_addr strictly alternates ports each clk.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Two-port round-robin write arbiter for the frame-buffer write port.
// A single registered output slot carries one beat; a burst limit bounds how long one port may hog the slot.
module fb_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int WBEN_WIDTH = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic [ADDR_WIDTH-1:0] in0_addr,
   input  logic [WBEN_WIDTH-1:0] in0_wben,
   input  logic                  in0_rts,
   output logic                  in0_rtr,
   input  logic [DATA_WIDTH-1:0] in1_data,
   input  logic [ADDR_WIDTH-1:0] in1_addr,
   input  logic [WBEN_WIDTH-1:0] in1_wben,
   input  logic                  in1_rts,
   output logic                  in1_rtr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WBEN_WIDTH-1:0] mem_wben,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  cur_grant
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t           state, state_nxt;
   logic             last_served, last_served_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

   logic                  slot_free;
   logic                  xfer0, xfer1, xfer;
   logic                  gnt_port, own_rts, oth_rts, own_xfer;
   state_t                oth_state;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WBEN_WIDTH-1:0] sel_wben;

   logic [DATA_WIDTH-1:0] data_p1;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic [WBEN_WIDTH-1:0] wben_p1;
   logic                  vld_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
   endfunction

   // Ready depends only on state and slot occupancy, never on rts.
   assign slot_free = !vld_p1 || mem_ready;
   assign in0_rtr   = (state == GRANT0) && slot_free;
   assign in1_rtr   = (state == GRANT1) && slot_free;
   assign xfer0     = in0_rts && in0_rtr;
   assign xfer1     = in1_rts && in1_rtr;
   assign xfer      = xfer0 || xfer1;

   assign gnt_port  = (state == GRANT1);
   assign own_rts   = gnt_port ? in1_rts : in0_rts;
   assign oth_rts   = gnt_port ? in0_rts : in1_rts;
   assign own_xfer  = gnt_port ? xfer1 : xfer0;
   assign oth_state = gnt_port ? GRANT0 : GRANT1;
   assign cur_grant = gnt_port;

   assign sel_data  = gnt_port ? in1_data : in0_data;
   assign sel_addr  = gnt_port ? in1_addr : in0_addr;
   assign sel_wben  = gnt_port ? in1_wben : in0_wben;

   always_comb begin
      state_nxt       = state;
      burst_cnt_nxt   = burst_cnt;
      last_served_nxt = last_served;
      case (state)
         IDLE: begin
            burst_cnt_nxt = '0;
            if (in0_rts && in1_rts) state_nxt = last_served ? GRANT0 : GRANT1;
            else if (in0_rts)       state_nxt = GRANT0;
            else if (in1_rts)       state_nxt = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (!own_rts) begin
               state_nxt       = oth_rts ? oth_state : IDLE;
               burst_cnt_nxt   = '0;
               last_served_nxt = gnt_port;
            end else if (own_xfer) begin
               // Burst-limit handover happens on the last beat, so the other port follows without a bubble.
               if (burst_cnt == CNT_LAST && oth_rts) begin
                  state_nxt       = oth_state;
                  burst_cnt_nxt   = '0;
                  last_served_nxt = gnt_port;
               end else begin
                  burst_cnt_nxt = sat_inc(burst_cnt);
               end
            end
         end
         default: begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= 1'b1;
         burst_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         last_served <= last_served_nxt;
         burst_cnt   <= burst_cnt_nxt;
      end
   end

   // Stage p1: registered output slot toward the frame buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         addr_p1 <= '0;
         wben_p1 <= '0;
      end else if (xfer) begin
         vld_p1  <= 1'b1;
         data_p1 <= sel_data;
         addr_p1 <= sel_addr;
         wben_p1 <= sel_wben;
      end else if (mem_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign mem_data  = data_p1;
   assign mem_addr  = addr_p1;
   assign mem_wben  = wben_p1;
   assign mem_valid = vld_p1;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: per-port expected queues filled on acceptance,
// a monitor consuming memory beats, and arbitration order derived from the round-robin rules.
`timescale 1ns/1ps
module tb_fb_write_arbiter;
   localparam int MB = 8;

   typedef struct packed {
      logic [31:0] data;
      logic [16:0] addr;
      logic [3:0]  wben;
   } beat_t;

   typedef struct {
      beat_t b;
      int    cyc;
      logic  port;
      logic  grant;
   } log_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in0_data = '0, in1_data = '0, mem_data;
   logic [16:0] in0_addr = '0, in1_addr = '0, mem_addr;
   logic [3:0]  in0_wben = '0, in1_wben = '0, mem_wben;
   logic        in0_rts = 1'b0, in1_rts = 1'b0, in0_rtr, in1_rtr;
   logic        mem_valid, mem_ready, cur_grant;
   logic        rdy_main = 1'b1, rdy_rand = 1'b1, rand_mode = 1'b0;

   logic [31:0] b_in0_data = '0, b_in1_data = '0, b_mem_data;
   logic [16:0] b_in0_addr = '0, b_in1_addr = '0, b_mem_addr;
   logic [3:0]  b_in0_wben = 4'hF, b_in1_wben = 4'hF, b_mem_wben;
   logic        b_in0_rts = 1'b0, b_in1_rts = 1'b0, b_in0_rtr, b_in1_rtr;
   logic        b_mem_valid, b_mem_ready, b_cur_grant;
   logic        b_run = 1'b0;
   logic        bx0 = 1'b0, bx1 = 1'b0;
   int          b_a0 = 0, b_a1 = 0, b_idx = 0, b_prev = 0;

   beat_t src0[$], src1[$], exp0[$], exp1[$];
   log_t  lg[$];
   int    checks = 0, failures = 0, cyc = 0, t_rts0 = -1;
   logic  x0 = 1'b0, x1 = 1'b0;

   int    exp_port[$], sw_idx[$];
   int    rem[2];
   int    cur_p, chunk;
   beat_t hold;

   always #5 clk = ~clk;
   assign mem_ready   = rand_mode ? rdy_rand : rdy_main;
   assign b_mem_ready = 1'b1;

   fb_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .WBEN_WIDTH(4), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .in0_data(in0_data), .in0_addr(in0_addr), .in0_wben(in0_wben), .in0_rts(in0_rts), .in0_rtr(in0_rtr),
      .in1_data(in1_data), .in1_addr(in1_addr), .in1_wben(in1_wben), .in1_rts(in1_rts), .in1_rtr(in1_rtr),
      .mem_data(mem_data), .mem_addr(mem_addr), .mem_wben(mem_wben), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .cur_grant(cur_grant)
   );

   fb_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .WBEN_WIDTH(4), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst(rst),
      .in0_data(b_in0_data), .in0_addr(b_in0_addr), .in0_wben(b_in0_wben), .in0_rts(b_in0_rts), .in0_rtr(b_in0_rtr),
      .in1_data(b_in1_data), .in1_addr(b_in1_addr), .in1_wben(b_in1_wben), .in1_rts(b_in1_rts), .in1_rtr(b_in1_rtr),
      .mem_data(b_mem_data), .mem_addr(b_mem_addr), .mem_wben(b_mem_wben), .mem_valid(b_mem_valid),
      .mem_ready(b_mem_ready), .cur_grant(b_cur_grant)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic beat_t rand_beat(input logic port);
      beat_t b;
      b.data = {port, 31'($urandom)};
      b.addr = 17'($urandom);
      b.wben = 4'($urandom);
      return b;
   endfunction

   function automatic beat_t seq_beat(input int port, input int data, input int addr);
      beat_t b;
      b.data = {port[0], 31'(data)};
      b.addr = 17'(addr);
      b.wben = 4'hF;
      return b;
   endfunction

   task automatic wait_log(input int n, input int budget, input string name);
      int k = 0;
      while (lg.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (lg.size() < n) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout beats=%0d required=%0d", name, lg.size(), n);
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #3;
      rst = 1'b1;
      src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      lg.delete();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Acceptance detection: a handshake seen here completes at the next rising edge.
   always @(negedge clk) begin
      x0 = in0_rts & in0_rtr;
      x1 = in1_rts & in1_rtr;
      if (x0) exp0.push_back({in0_data, in0_addr, in0_wben});
      if (x1) exp1.push_back({in1_data, in1_addr, in1_wben});
   end

   always begin
      @(posedge clk);
      #1;
      if (x0 && src0.size() > 0) void'(src0.pop_front());
      if (x1 && src1.size() > 0) void'(src1.pop_front());
      if (src0.size() > 0 && ((in0_rts && !x0) || !rand_mode || $urandom_range(0, 3) != 0)) begin
         {in0_data, in0_addr, in0_wben} = src0[0];
         in0_rts = 1'b1;
         if (t_rts0 < 0) t_rts0 = cyc;
      end else begin
         in0_rts = 1'b0;
      end
      if (src1.size() > 0 && ((in1_rts && !x1) || !rand_mode || $urandom_range(0, 3) != 0)) begin
         {in1_data, in1_addr, in1_wben} = src1[0];
         in1_rts = 1'b1;
      end else begin
         in1_rts = 1'b0;
      end
      rdy_rand = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin : monitor
      beat_t got, want;
      logic  p;
      if (!rst && mem_valid && mem_ready) begin
         got = {mem_data, mem_addr, mem_wben};
         p   = mem_data[31];
         if ((p && exp1.size() == 0) || (!p && exp0.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected port=%0d actual=%h required=none", p, got);
         end else begin
            want = p ? exp1.pop_front() : exp0.pop_front();
            check("beat", 64'(got), 64'(want));
         end
         lg.push_back('{b:got, cyc:cyc, port:p, grant:cur_grant});
      end
      if (!rst) check("rtr_exclusive", 64'(in0_rtr & in1_rtr), 64'd0);
      if (!rst && mem_valid && !mem_ready) check("rtr_when_full", 64'({in1_rtr, in0_rtr}), 64'd0);
   end

   always begin
      @(posedge clk);
      #1;
      if (bx0) b_a0 = b_a0 + 1;
      if (bx1) b_a1 = b_a1 + 1;
      b_in0_rts  = b_run;
      b_in1_rts  = b_run;
      b_in0_addr = 17'(b_a0);
      b_in1_addr = 17'(32'h10000 + b_a1);
      b_in0_data = 32'(b_a0);
      b_in1_data = 32'(32'h10000 + b_a1);
   end

   // MAX_BURST=1 instance: beat i must come from port i%2 with that port's next address.
   always @(negedge clk) begin
      bx0 = b_in0_rts & b_in0_rtr;
      bx1 = b_in1_rts & b_in1_rtr;
      if (!rst && b_run && b_mem_valid && b_idx < 12) begin
         check("alt_addr", 64'(b_mem_addr), 64'(((b_idx % 2) != 0 ? 32'h10000 : 32'h0) + 32'(b_idx / 2)));
         if (b_idx > 0) check("alt_nogap", 64'(cyc - b_prev), 64'd1);
         b_prev = cyc;
         b_idx  = b_idx + 1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_mem_bus", 64'({mem_data, mem_addr, mem_wben}), 64'd0);
      check("rst_rtr", 64'({in1_rtr, in0_rtr}), 64'd0);

      // Lone port 0, four beats
      @(posedge clk);
      #3;
      for (int i = 0; i < 4; i++) src0.push_back(seq_beat(0, 32'hA0 + i, 32'h101 + i));
      wait_log(4, 50, "single");
      if (lg.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check("single_addr", 64'(lg[i].b.addr), 64'(32'h101 + i));
            check("single_data", 64'(lg[i].b.data), 64'(32'hA0 + i));
         end
         check("single_latency", 64'(lg[0].cyc - t_rts0), 64'd2);
         check("single_back2back", 64'(lg[3].cyc - lg[0].cyc), 64'd3);
      end

      // Both ports contend from reset, 12 beats each
      reset_dut();
      @(posedge clk);
      #3;
      for (int i = 0; i < 12; i++) begin
         src0.push_back(rand_beat(1'b0));
         src1.push_back(rand_beat(1'b1));
      end
      exp_port.delete();
      sw_idx.delete();
      rem[0] = 12; rem[1] = 12; cur_p = 0;
      while (rem[0] + rem[1] > 0) begin
         chunk = (rem[1-cur_p] > 0 && rem[cur_p] > MB) ? MB : rem[cur_p];
         for (int i = 0; i < chunk; i++) exp_port.push_back(cur_p);
         if (rem[cur_p] - chunk > 0) sw_idx.push_back(exp_port.size() - 1);
         rem[cur_p] = rem[cur_p] - chunk;
         cur_p = 1 - cur_p;
      end
      wait_log(24, 200, "contend");
      if (lg.size() >= 24) begin
         for (int i = 0; i < 24; i++) check("contend_port", 64'(lg[i].port), 64'(exp_port[i]));
         foreach (sw_idx[j]) check("contend_nogap", 64'(lg[sw_idx[j] + 1].cyc - lg[sw_idx[j]].cyc), 64'd1);
      end

      // Backpressure for three cycles while a beat is held
      lg.delete();
      @(posedge clk);
      #3;
      for (int i = 0; i < 6; i++) src0.push_back(seq_beat(0, 32'h300 + i, 32'h200 + i));
      wait_log(2, 50, "stall_pre");
      @(posedge clk);
      #1;
      rdy_main = 1'b0;
      @(negedge clk);
      check("stall_valid", 64'(mem_valid), 64'd1);
      check("stall_rtr", 64'(in0_rtr), 64'd0);
      hold = {mem_data, mem_addr, mem_wben};
      repeat (2) begin
         @(negedge clk);
         check("stall_hold", 64'({mem_data, mem_addr, mem_wben}), 64'(hold));
         check("stall_rtr", 64'(in0_rtr), 64'd0);
      end
      @(posedge clk);
      #1;
      rdy_main = 1'b1;
      wait_log(6, 50, "stall_post");
      repeat (5) @(negedge clk);
      check("stall_count", 64'(lg.size()), 64'd6);

      // Long lone stream on port 0
      lg.delete();
      @(posedge clk);
      #3;
      for (int i = 0; i < 20; i++) src0.push_back(seq_beat(0, 32'h400 + i, 32'h500 + i));
      wait_log(20, 100, "stream");
      if (lg.size() >= 20) begin
         check("stream_nogap", 64'(lg[19].cyc - lg[0].cyc), 64'd19);
         for (int i = 0; i < 20; i++) check("stream_grant", 64'(lg[i].grant), 64'd0);
      end

      // Asynchronous reset in the middle of a burst
      lg.delete();
      @(posedge clk);
      #3;
      for (int i = 0; i < 10; i++) src0.push_back(rand_beat(1'b0));
      wait_log(3, 50, "rst_mid_pre");
      @(posedge clk);
      #3;
      rst = 1'b1;
      src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
      #1;
      check("rst_mid_valid", 64'(mem_valid), 64'd0);
      check("rst_mid_rtr", 64'({in1_rtr, in0_rtr}), 64'd0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      lg.delete();
      for (int i = 0; i < 2; i++) begin
         src0.push_back(rand_beat(1'b0));
         src1.push_back(rand_beat(1'b1));
      end
      wait_log(4, 50, "rst_tie");
      if (lg.size() >= 4) begin
         check("rst_tie_first", 64'(lg[0].port), 64'd0);
         check("rst_tie_third", 64'(lg[2].port), 64'd1);
      end

      // Randomized traffic, gaps and backpressure
      lg.delete();
      @(posedge clk);
      #3;
      rand_mode = 1'b1;
      for (int i = 0; i < 150; i++) begin
         src0.push_back(rand_beat(1'b0));
         src1.push_back(rand_beat(1'b1));
      end
      wait_log(300, 5000, "random");
      @(posedge clk);
      #3;
      rand_mode = 1'b0;
      repeat (4) @(negedge clk);
      check("random_drained", 64'(exp0.size() + exp1.size()), 64'd0);

      // MAX_BURST=1 instance, both ports streaming
      reset_dut();
      @(posedge clk);
      #3;
      b_run = 1'b1;
      for (int k = 0; k < 100 && b_idx < 12; k++) @(negedge clk);
      if (b_idx < 12) begin
         checks++;
         failures++;
         $display("FAIL alt_timeout beats=%0d required=12", b_idx);
      end
      @(posedge clk);
      #3;
      b_run = 1'b0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
